bo_datapath: RTL and testbench

- Operative block (datapath) that sits on the other end of the control-block interface. It consumes the control word (m0, m1, m2, lx, ls, lh, h, done) issued by the control FSM each cycle.
- Holds three working registers X, S and H, plus an ALU and condition flags.
- Returns zero/neg status to the controller.
- Presents the final result on a valid/ready output handshake, held until it is consumed.

---
 rtl/bo_datapath.sv | 106 ++++++++++
 tb/tb_bo_datapath.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/bo_datapath.sv
// bo_datapath: operative half of a controller/datapath pair. Holds the
// working registers X, S, H, an ALU with operand muxes, registered zero/neg
// status flags, and a valid/ready result port with a sticky overrun flag.
module bo_datapath #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] x_in,
   input  logic [1:0]   m0,
   input  logic [1:0]   m1,
   input  logic [1:0]   m2,
   input  logic         lx,
   input  logic         ls,
   input  logic         lh,
   input  logic         h,
   input  logic         done,
   output logic         zero,
   output logic         neg,
   output logic [N-1:0] res,
   output logic         res_valid,
   input  logic         res_ready,
   output logic         ovr
);

   logic [N-1:0] x_q, x_d, s_q, s_d, h_q, h_d, res_q, res_d;
   logic         zero_q, zero_d, neg_q, neg_d, vld_q, vld_d, ovr_q, ovr_d;
   logic [N-1:0] opa, opb, alu;
   logic         xfer;

   // Operand muxes and ALU; always fed from pre-edge register values.
   always_comb begin
      unique case (m0)
         2'b00:   opa = x_q;
         2'b01:   opa = s_q;
         2'b10:   opa = h_q;
         default: opa = N'(1);
      endcase
      unique case (m1)
         2'b00:   opb = x_q;
         2'b01:   opb = s_q;
         2'b10:   opb = h_q;
         default: opb = '0;
      endcase
      unique case (m2)
         2'b00:   alu = opa + opb;
         2'b01:   alu = opa - opb;
         2'b10:   alu = {opa[N-2:0], 1'b0};
         default: alu = opa;
      endcase
   end

   assign xfer = vld_q & res_ready;

   // Next-state for registers, flags and the result handshake.
   always_comb begin
      x_d    = lx ? x_in : x_q;
      s_d    = ls ? alu  : s_q;
      h_d    = lh ? alu  : h_q;
      zero_d = h  ? (alu == '0) : zero_q;
      neg_d  = h  ? alu[N-1]    : neg_q;
      res_d  = res_q;
      vld_d  = vld_q;
      ovr_d  = ovr_q;
      if (done && (!vld_q || xfer)) begin
         // Publishes the pre-edge S, so a same-cycle ls is not yet visible.
         res_d = s_q;
         vld_d = 1'b1;
      end else if (done) begin
         // Consumer still holds the previous result: keep it, flag the loss.
         ovr_d = 1'b1;
      end else if (xfer) begin
         vld_d = 1'b0;
      end
   end

   // State registers with asynchronous active-low clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x_q    <= '0;
         s_q    <= '0;
         h_q    <= '0;
         res_q  <= '0;
         zero_q <= 1'b0;
         neg_q  <= 1'b0;
         vld_q  <= 1'b0;
         ovr_q  <= 1'b0;
      end else begin
         x_q    <= x_d;
         s_q    <= s_d;
         h_q    <= h_d;
         res_q  <= res_d;
         zero_q <= zero_d;
         neg_q  <= neg_d;
         vld_q  <= vld_d;
         ovr_q  <= ovr_d;
      end
   end

   assign zero      = zero_q;
   assign neg       = neg_q;
   assign res       = res_q;
   assign res_valid = vld_q;
   assign ovr       = ovr_q;

endmodule

// File: tb/tb_bo_datapath.sv
// Self-checking bench for bo_datapath: directed scenarios then random
// control words, all compared against a behavioural model every cycle.
module tb_bo_datapath;
  localparam int N = 8;

  logic         gclk = 1'b0;
  logic         grst_n;
  logic [N-1:0] x_in;
  logic [1:0]   m0, m1, m2;
  logic         lx, ls, lh, h, done, res_ready;
  logic         zero, neg, res_valid, ovr;
  logic [N-1:0] res;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [N-1:0] mx, ms, mh, mres;
  logic         mzero, mneg, mvld, movr;

  bo_datapath #(.N(N)) dut (
    .clk(gclk), .rst(grst_n), .x_in(x_in), .m0(m0), .m1(m1), .m2(m2),
    .lx(lx), .ls(ls), .lh(lh), .h(h), .done(done),
    .zero(zero), .neg(neg), .res(res), .res_valid(res_valid),
    .res_ready(res_ready), .ovr(ovr)
  );

  always #5 gclk = ~gclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mx = 0; ms = 0; mh = 0; mres = 0;
    mzero = 0; mneg = 0; mvld = 0; movr = 0;
  endtask

  function automatic logic [N-1:0] pick(input logic [1:0] sel, input logic [N-1:0] c);
    case (sel)
      2'd0: return mx;
      2'd1: return ms;
      2'd2: return mh;
      default: return c;
    endcase
  endfunction

  task automatic cmp_all();
    chk("zero", zero, mzero);
    chk("neg", neg, mneg);
    chk("res_valid", res_valid, mvld);
    chk("ovr", ovr, movr);
    if (mvld) chk("res", res, mres);
  endtask

  // one clock with current inputs; model advances from pre-edge state
  task automatic step();
    int a, b, r;
    logic [N-1:0] alu;
    logic nx_vld, nx_ovr; logic [N-1:0] nx_res;
    a = pick(m0, 8'd1);
    b = pick(m1, 8'd0);
    case (m2)
      2'd0: r = a + b;
      2'd1: r = a - b;
      2'd2: r = a * 2;
      default: r = a;
    endcase
    alu = r[N-1:0];
    nx_vld = mvld; nx_ovr = movr; nx_res = mres;
    if (done && (!mvld || res_ready)) begin nx_res = ms; nx_vld = 1; end
    else if (done) nx_ovr = 1;
    else if (mvld && res_ready) nx_vld = 0;
    @(posedge gclk); #1;
    if (lx) mx = x_in;
    if (ls) ms = alu;
    if (lh) mh = alu;
    if (h) begin mzero = (alu == 0); mneg = alu[N-1]; end
    mvld = nx_vld; movr = nx_ovr; mres = nx_res;
    cmp_all();
  endtask

  task automatic drive(input logic [7:0] xv, input logic [1:0] a, input logic [1:0] b,
                       input logic [1:0] op, input logic [5:0] ctl);
    // ctl = {lx, ls, lh, h, done, res_ready}
    x_in = xv; m0 = a; m1 = b; m2 = op;
    {lx, ls, lh, h, done, res_ready} = ctl;
    step();
  endtask

  // ctl bit helpers
  localparam logic [5:0] LX = 6'b100000, LS = 6'b010000, LH = 6'b001000,
                         HF = 6'b000100, DN = 6'b000010, RY = 6'b000001;

  initial begin
    x_in = 0; m0 = 0; m1 = 0; m2 = 0;
    {lx, ls, lh, h, done, res_ready} = '0;
    grst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge gclk);
    #1;
    chk("rst_vld", res_valid, 0); chk("rst_ovr", ovr, 0);
    chk("rst_res", res, 0); chk("rst_zero", zero, 0); chk("rst_neg", neg, 0);
    grst_n = 1'b1;
    drive(8'h00, 0, 0, 0, 0);
    // X=2A, then S=X, publish -> res 2A
    drive(8'h2A, 0, 0, 0, LX);
    drive(8'h00, 0, 0, 3, LS);
    drive(8'h00, 0, 0, 0, DN | RY);
    chk("load_x", res, 8'h2A);
    // accumulate: X=5, S=0, S+=X three times
    drive(8'h05, 0, 0, 0, LX | RY);
    drive(8'h00, 0, 0, 1, LS);
    repeat (3) drive(8'h00, 1, 0, 0, LS);
    drive(8'h00, 0, 0, 0, DN | RY);
    chk("acc_res", res, 8'h0F); chk("acc_vld", res_valid, 1);
    // subtract 3-5 with flags
    drive(8'h03, 0, 0, 0, LX | RY);
    drive(8'h00, 0, 0, 3, LS);
    drive(8'h05, 0, 0, 0, LX);
    drive(8'h00, 1, 0, 1, LS | HF);
    chk("sub_neg", neg, 1); chk("sub_zero", zero, 0);
    drive(8'h00, 0, 0, 0, DN | RY);
    chk("sub_res", res, 8'hFE);
    drive(8'h03, 0, 0, 0, LX | RY);
    drive(8'h00, 0, 0, 3, LS);
    drive(8'h00, 1, 0, 1, LS | HF);
    chk("sub0_zero", zero, 1); chk("sub0_neg", neg, 0);
    // shift H=81 -> 02, then S=1 from constants
    drive(8'h81, 0, 0, 0, LX);
    drive(8'h00, 0, 0, 3, LH);
    drive(8'h00, 2, 0, 2, LH);
    drive(8'h00, 2, 0, 3, LS);
    drive(8'h00, 0, 0, 0, DN | RY);
    chk("shl_res", res, 8'h02);
    drive(8'h00, 3, 3, 0, LS | RY);
    drive(8'h00, 0, 0, 0, DN | RY);
    chk("const_res", res, 8'h01);
    // backpressure
    drive(8'h00, 0, 0, 0, RY);
    chk("drain", res_valid, 0);
    drive(8'h00, 0, 0, 0, DN);
    chk("bp_vld", res_valid, 1); chk("bp_res", res, 8'h01);
    drive(8'h00, 3, 3, 0, LS);  // S stays 1; nothing visible yet
    drive(8'h00, 1, 1, 0, LS | DN);  // S=2, but res must hold 1
    chk("bp_hold", res, 8'h01); chk("bp_ovr", ovr, 1);
    drive(8'h00, 0, 0, 0, RY);
    chk("bp_clr", res_valid, 0); chk("ovr_sticky", ovr, 1);
    // same-edge done+ls: S=7, alu=9
    drive(8'h07, 0, 0, 0, LX);
    drive(8'h00, 0, 0, 3, LS);
    drive(8'h02, 0, 0, 0, LX);
    drive(8'h00, 1, 0, 0, LS | DN | RY);
    chk("same_res", res, 8'h07);
    drive(8'h00, 0, 0, 0, DN | RY);
    chk("same_s", res, 8'h09); chk("same_vld", res_valid, 1);
    // async reset mid-cycle while valid
    #3 grst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_vld", res_valid, 0); chk("arst_ovr", ovr, 0);
    @(posedge gclk); #1;
    grst_n = 1'b1;
    // random phase
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        #2 grst_n = 1'b0;
        #1 model_reset();
        cmp_all();
        @(posedge gclk); #1;
        grst_n = 1'b1;
      end
      x_in = N'($urandom); m0 = 2'($urandom); m1 = 2'($urandom); m2 = 2'($urandom);
      lx = ($urandom_range(0, 2) == 0); ls = ($urandom_range(0, 1) == 0);
      lh = ($urandom_range(0, 2) == 0); h = ($urandom_range(0, 1) == 0);
      done = ($urandom_range(0, 3) == 0); res_ready = ($urandom_range(0, 1) == 0);
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
